// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: default geometry and pending-vector type for the multiport register file
package regfile_mp_pkg;
  localparam int N_DEF = 16;
  localparam int R_DEF = 3;
  localparam int NR_DEF = 2;
  localparam int NW_DEF = 2;
  typedef logic [2**R_DEF-1:0] pend_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/reserve bus of the multiport register file
interface regfile_mp_if #(
  parameter int N = 16,
  parameter int R = 3,
  parameter int NR = 2,
  parameter int NW = 2
);
  logic [NR-1:0][R-1:0] ra;
  logic [NR-1:0][N-1:0] rd;
  logic [NR-1:0] rbusy;
  logic [NW-1:0] we;
  logic [NW-1:0][R-1:0] wa;
  logic [NW-1:0][N-1:0] wd;
  logic rsv_en;
  logic [R-1:0] rsv_addr;
  logic [R:0] busy_cnt;
  modport master(output ra, we, wa, wd, rsv_en, rsv_addr, input rd, rbusy, busy_cnt);
  modport slave(input ra, we, wa, wd, rsv_en, rsv_addr, output rd, rbusy, busy_cnt);
endinterface

// File: rtl/regfile_mp_popcount.sv
// popcount: number of set bits in a W-bit vector
module popcount #(
  parameter int W = 8,
  localparam int CW = $clog2(W + 1)
) (
  input logic [W-1:0] v,
  output logic [CW-1:0] c
);
  always_comb begin
    c = '0;
    for (int k = 0; k < W; k++) c = c + CW'(v[k]);
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multiport register file with pending scoreboard; r0 is hardwired zero.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF,
  parameter int NR = NR_DEF,
  parameter int NW = NW_DEF
) (
  input logic clk,
  input logic rst_n,
  regfile_mp_if.slave b
);
  localparam int D = 2**R;
  logic [D-1:0][N-1:0] rf, rf_nx;
  logic [D-1:0] pend, pend_nx;
  logic [R:0] cnt_nx;
  // later write ports overwrite earlier ones; the reserve is applied last so it wins
  always_comb begin
    rf_nx = rf;
    pend_nx = pend;
    for (int j = 0; j < NW; j++)
      if (b.we[j] && b.wa[j] != '0) begin
        rf_nx[b.wa[j]] = b.wd[j];
        pend_nx[b.wa[j]] = 1'b0;
      end
    if (b.rsv_en && b.rsv_addr != '0) pend_nx[b.rsv_addr] = 1'b1;
  end
  popcount #(.W(D)) u_pc (.v(pend_nx), .c(cnt_nx));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf <= '0;
      pend <= '0;
      b.busy_cnt <= '0;
    end else begin
      rf <= rf_nx;
      pend <= pend_nx;
      b.busy_cnt <= cnt_nx;
    end
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      b.rd[i] = rf[b.ra[i]];
      b.rbusy[i] = pend[b.ra[i]];
`ifdef REGFILE_MP_BYPASS_EN
      for (int j = 0; j < NW; j++)
        if (rst_n && b.we[j] && b.wa[j] == b.ra[i] && b.ra[i] != '0) begin
          b.rd[i] = b.wd[j];
          b.rbusy[i] = b.rsv_en && b.rsv_addr == b.ra[i];
        end
`endif
    end
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter N, default 16: register data width in bits.
REQ-002 SHALL have parameter R, default 3: address width; depth is 2**R registers.
REQ-003 SHALL have parameter NR, default 2: number of read ports, legal range 1..4.
REQ-004 SHALL have parameter NW, default 2: number of write ports, legal range 1..2.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port ra  input  NR x R  read addresses, one per read port.
REQ-008 SHALL have port rd  output  NR x N  read data, one per read port.
REQ-009 SHALL have port rbusy  output  NR  pending flag of the register addressed by each read port.
REQ-010 SHALL have port we  input  NW  write enables.
REQ-011 SHALL have port wa  input  NW x R  write addresses.
REQ-012 SHALL have port wd  input  NW x N  write data.
REQ-013 SHALL have port rsv_en  input  1  reserve strobe: marks a destination register pending.
REQ-014 SHALL have port rsv_addr  input  R  address of the register to reserve.
REQ-015 SHALL have port busy_cnt  output  R+1  number of registers currently pending.

Function
REQ-016 Register 0 SHALL read as 0, ignore all writes and never become pending.
REQ-017 Reads SHALL be combinational: rd[i] = stored value of rf[ra[i]] in the same cycle.
REQ-018 When we[j]=1 and wa[j]!=0, rf[wa[j]] SHALL take wd[j] on the next rising edge.
REQ-019 When several write ports target the same address in one cycle, the highest-indexed port SHALL win.
REQ-020 Each register SHALL have a pending bit; rbusy[i] SHALL equal pending[ra[i]].
REQ-021 rsv_en=1 with rsv_addr!=0 SHALL set pending[rsv_addr] on the next edge.
REQ-022 An enabled write to a nonzero address SHALL clear pending[wa] on the next edge.
REQ-023 If a reserve and a write target the same register in one cycle, the reserve SHALL win, so the pending bit ends set.
REQ-024 busy_cnt SHALL be a registered population count of the pending bits, updated on the same edge as those bits.
REQ-025 busy_cnt SHALL never exceed 2**R-1, because register 0 is excluded.

Reset
REQ-026 rst_n=0 SHALL, without waiting for clk, clear all registers to 0, all pending bits to 0 and busy_cnt to 0.
REQ-027 While rst_n=0, writes and reserves SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight write or reserve.
REQ-029 After reset, every rd SHALL output 0 and every rbusy SHALL output 0.

Configuration
REQ-030 Macro REGFILE_MP_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 With REGFILE_MP_BYPASS_EN defined:
- an enabled same-cycle write to ra[i]!=0 SHALL drive rd[i]=wd (highest-indexed matching port wins);
- rbusy[i] SHALL read 0 in that case, unless a same-cycle reserve also targets ra[i].
REQ-032 With REGFILE_MP_BYPASS_EN undefined:
- reads SHALL return only stored values;
- the written value SHALL become visible in the cycle after the edge.

Structure
REQ-033 Package regfile_mp_pkg SHALL hold the default constants (N, R, NR, NW) and a typedef for the pending-bit vector.
REQ-034 Sub-module popcount SHALL compute busy_cnt from the pending vector, parametrised by input width.

Verification
REQ-035 Reset check:
- stimulus: rst_n=0 asynchronously, mid-clock, after writes to r3=16'h1234;
- required: rd=0 for all ra, rbusy=0 and busy_cnt=0 immediately, before any edge.
REQ-036 Write/read check:
- stimulus: we[0]=1, wa[0]=5, wd[0]=16'hBEEF; then ra[0]=5, ra[1]=0;
- required: rd[0]=16'hBEEF after the edge, rd[1]=0.
REQ-037 Write-port conflict check:
- stimulus: we=2'b11, wa[0]=wa[1]=2, wd[0]=16'h1111, wd[1]=16'h2222;
- required: rf[2]=16'h2222.
REQ-038 Scoreboard check:
- stimulus: reserve r4 and r6, then write r4;
- required: busy_cnt goes 0 -> 1 -> 2 -> 1; rbusy for ra=4 clears after the write edge; reserving r0 leaves busy_cnt unchanged.
REQ-039 Reserve/write collision check:
- stimulus: rsv_addr=7 and a write to wa=7 in the same cycle;
- required: pending[7]=1 afterwards and rf[7] is updated.
REQ-040 Bypass check:
- stimulus: same-cycle we[0]=1, wa[0]=3, wd[0]=16'h00AA, ra[0]=3;
- required with REGFILE_MP_BYPASS_EN defined: rd[0]=16'h00AA in that cycle;
- required with it undefined: the old value in that cycle, 16'h00AA in the next cycle.
